// File: rtl/mproc_prog_loader_pkg.sv
// Shared constants and state type for the mproc boot-time program loader.
// The address and data widths match the 128x16 program RAM that the loader writes.
package mproc_prog_loader_pkg;

   localparam int MPROC_ADDR_W = 7;
   localparam int MPROC_DATA_W = 16;
   localparam int MPROC_DEPTH  = 128;

   typedef enum logic [1:0] {
      LD_IDLE = 2'd0,
      LD_LOAD = 2'd1,
      LD_FILL = 2'd2,
      LD_DONE = 2'd3
   } loader_state_e;

endpackage

// File: rtl/mproc_prog_loader.sv
// Streams a program image into the program RAM starting at address 0, then pads the
// remaining addresses with FILL_WORD. The CPU is kept in reset until the image is complete.
module mproc_prog_loader
   import mproc_prog_loader_pkg::*;
#(
   parameter int                ADDR_W    = MPROC_ADDR_W,
   parameter int                DATA_W    = MPROC_DATA_W,
   parameter logic [DATA_W-1:0] FILL_WORD = '0
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic              in_valid,
   input  logic [DATA_W-1:0] in_data,
   input  logic              in_last,
   output logic              in_ready,
   output logic              mem_wr,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_din,
   output logic              cpu_hold,
   output logic              busy,
   output logic              done,
   output logic              truncated,
   output logic [ADDR_W:0]   word_count
);

   localparam logic [ADDR_W-1:0] LAST_ADDR = '1;
   localparam logic [ADDR_W-1:0] PTR_ONE   = {{(ADDR_W-1){1'b0}}, 1'b1};
   localparam logic [ADDR_W:0]   CNT_ONE   = {{ADDR_W{1'b0}}, 1'b1};
   localparam logic [ADDR_W:0]   CNT_MAX   = {1'b1, {ADDR_W{1'b0}}};

   loader_state_e     state_q, state_d;
   logic [ADDR_W-1:0] wptr_q, wptr_d;
   logic [ADDR_W:0]   count_q, count_d;
   logic              trunc_q, trunc_d;
   logic              wr_q, wr_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] din_q, din_d;
   logic              hold_q, hold_d;
   logic              handshake;

   assign in_ready   = (state_q == LD_LOAD);
   assign handshake  = in_valid & in_ready;
   assign busy       = (state_q == LD_LOAD) || (state_q == LD_FILL);
   assign done       = (state_q == LD_DONE);
   assign mem_wr     = wr_q;
   assign mem_addr   = addr_q;
   assign mem_din    = din_q;
   assign cpu_hold   = hold_q;
   assign truncated  = trunc_q;
   assign word_count = count_q;

   // All RAM writes are registered: an accepted word appears on the RAM port one cycle later.
   always_comb begin
      state_d = state_q;
      wptr_d  = wptr_q;
      count_d = count_q;
      trunc_d = trunc_q;
      wr_d    = 1'b0;
      addr_d  = addr_q;
      din_d   = din_q;

      case (state_q)
         LD_IDLE, LD_DONE: begin
            if (start) begin
               state_d = LD_LOAD;
               wptr_d  = '0;
               count_d = '0;
               trunc_d = 1'b0;
            end
         end
         LD_LOAD: begin
            if (handshake) begin
               wr_d   = 1'b1;
               addr_d = wptr_q;
               din_d  = in_data;
               wptr_d = wptr_q + PTR_ONE;
               if (count_q != CNT_MAX) begin
                  count_d = count_q + CNT_ONE;
               end
               if (wptr_q == LAST_ADDR) begin
                  state_d = LD_DONE;
                  trunc_d = ~in_last;
               end else if (in_last) begin
                  state_d = LD_FILL;
               end
            end
         end
         LD_FILL: begin
            wr_d   = 1'b1;
            addr_d = wptr_q;
            din_d  = FILL_WORD;
            wptr_d = wptr_q + PTR_ONE;
            if (wptr_q == LAST_ADDR) begin
               state_d = LD_DONE;
            end
         end
         default: state_d = LD_IDLE;
      endcase
   end

   // Hold follows the next state so it drops exactly as DONE is entered and rises with busy.
   assign hold_d = (state_d != LD_DONE);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= LD_IDLE;
         wptr_q  <= '0;
         count_q <= '0;
         trunc_q <= 1'b0;
         wr_q    <= 1'b0;
         addr_q  <= '0;
         din_q   <= '0;
         hold_q  <= 1'b1;
      end else begin
         state_q <= state_d;
         wptr_q  <= wptr_d;
         count_q <= count_d;
         trunc_q <= trunc_d;
         wr_q    <= wr_d;
         addr_q  <= addr_d;
         din_q   <= din_d;
         hold_q  <= hold_d;
      end
   end

endmodule
